// File: rtl/download_sdram_writer.sv
// download_sdram_writer: packs the HPS ROM download byte stream into 32-bit
// little-endian words and writes them to SDRAM through a small word FIFO.
// Optional feature macro: DOWNLOAD_CHECKSUM_EN adds a 16-bit byte-sum output.
//
// SDRAM handshake: sdram_req (with sdram_we) is the valid signal. Once raised,
// it stays high with sdram_addr/sdram_data/sdram_we stable until sdram_ack is
// sampled high. That ack cycle completes the transfer, and the head entry is
// popped. sdram_ack seen while sdram_req is low is ignored.
module download_sdram_writer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  FILL_BYTE  = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_wr,
  output logic [22:0] sdram_addr,
  output logic [31:0] sdram_data,
  output logic        sdram_we,
  output logic        sdram_req,
  input  logic        sdram_ack,
  output logic        busy,
  output logic        done,
  output logic        overflow,
`ifdef DOWNLOAD_CHECKSUM_EN
  output logic [15:0] checksum,
`endif
  output logic [1:0]  dbg_dl_state,
  output logic        dbg_req_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(FIFO_DEPTH);

  typedef enum logic [1:0] {D_IDLE, D_ACTIVE, D_FLUSH, D_DRAIN} dl_state_t;
  typedef enum logic {R_IDLE, R_WAIT} req_state_t;

  dl_state_t  dstate, dstate_next;
  req_state_t rstate, rstate_next;

  logic        dl_prev, start_pend, dl_rise, start, enter_active, wr_acc, drain_ok;
  logic [31:0] word_buf;
  logic [3:0]  mask;
  logic [22:0] word_addr;

  logic [22:0] in_waddr;
  logic [1:0]  in_lane;
  logic        addr_change;
  logic [31:0] base_buf, merged_buf;
  logic [3:0]  base_mask, merged_mask;
  logic        push0, push1, acc0, acc1, pop;
  logic [22:0] entry0_addr, entry1_addr;
  logic [31:0] entry0_data, entry1_data;

  logic [22:0] fifo_addr [FIFO_DEPTH];
  logic [31:0] fifo_data [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_next;
  logic [AW+1:0] space;

  // Lanes never received in a word are written as FILL_BYTE.
  function automatic logic [31:0] fill_word(input logic [31:0] d, input logic [3:0] m);
    logic [31:0] r;
    for (int n = 0; n < 4; n++) r[8*n +: 8] = m[n] ? d[8*n +: 8] : FILL_BYTE;
    return r;
  endfunction

  assign dl_rise      = ioctl_download && !dl_prev;
  assign start        = dl_rise || start_pend;
  assign enter_active = (dstate == D_IDLE) && start;
  assign wr_acc       = (dstate == D_ACTIVE) && ioctl_wr;
  assign drain_ok     = (count == '0) && (rstate == R_IDLE);
  assign pop          = (rstate == R_WAIT) && sdram_ack;
  assign in_waddr     = ioctl_addr[24:2];
  assign in_lane      = ioctl_addr[1:0];
  assign addr_change  = (mask != 4'h0) && (word_addr != in_waddr);

  // Packer: decide which words to enqueue this cycle (up to two when a byte
  // both closes out a partial word and lands in lane 3 of a new one).
  always_comb begin
    push0       = 1'b0;
    push1       = 1'b0;
    entry0_addr = word_addr;
    entry0_data = fill_word(word_buf, mask);
    base_buf    = addr_change ? 32'h0 : word_buf;
    base_mask   = addr_change ? 4'h0 : mask;
    merged_buf  = base_buf;
    merged_buf[{in_lane, 3'b000} +: 8] = ioctl_data;
    merged_mask = base_mask | (4'b0001 << in_lane);
    entry1_addr = in_waddr;
    entry1_data = fill_word(merged_buf, merged_mask);
    if (wr_acc) begin
      push0 = addr_change;
      push1 = (in_lane == 2'd3);
    end else if (dstate == D_FLUSH) begin
      push0 = (mask != 4'h0);
    end
  end

  // FIFO admission: a dequeue in the same cycle frees a slot for an enqueue.
  always_comb begin
    space      = DEPTH_W - {1'b0, count} + {{(AW+1){1'b0}}, pop};
    acc0       = push0 && (space != '0);
    acc1       = push1 && (space > {{(AW+1){1'b0}}, acc0});
    count_next = count + {{AW{1'b0}}, acc0} + {{AW{1'b0}}, acc1} - {{AW{1'b0}}, pop};
  end

  // Packer word buffer, lane mask and held word address.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_buf  <= 32'h0;
      mask      <= 4'h0;
      word_addr <= 23'h0;
    end else if (enter_active) begin
      mask <= 4'h0;
    end else if (wr_acc) begin
      if (in_lane == 2'd3) begin
        mask <= 4'h0;
      end else begin
        mask      <= merged_mask;
        word_buf  <= merged_buf;
        word_addr <= in_waddr;
      end
    end else if (dstate == D_FLUSH) begin
      mask <= 4'h0;
    end
  end

  // FIFO storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (acc0) begin
      fifo_addr[wr_ptr] <= entry0_addr;
      fifo_data[wr_ptr] <= entry0_data;
    end
    if (acc1) begin
      fifo_addr[wr_ptr + AW'(acc0)] <= entry1_addr;
      fifo_data[wr_ptr + AW'(acc0)] <= entry1_data;
    end
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(acc0) + AW'(acc1);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count_next;
      if (enter_active)
        overflow <= 1'b0;
      else if ((push0 && !acc0) || (push1 && !acc1))
        overflow <= 1'b1;
    end
  end

  // State registers, download edge detect, latched start and done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      dstate     <= D_IDLE;
      rstate     <= R_IDLE;
      dl_prev    <= 1'b0;
      start_pend <= 1'b0;
      done       <= 1'b0;
    end else begin
      dstate  <= dstate_next;
      rstate  <= rstate_next;
      dl_prev <= ioctl_download;
      done    <= (dstate == D_DRAIN) && drain_ok;
      if (enter_active)
        start_pend <= 1'b0;
      else if (dl_rise && dstate != D_IDLE)
        start_pend <= 1'b1;
    end
  end

  // Download FSM next state.
  always_comb begin
    dstate_next = dstate;
    case (dstate)
      D_IDLE:   if (start) dstate_next = D_ACTIVE;
      D_ACTIVE: if (!ioctl_download) dstate_next = D_FLUSH;
      D_FLUSH:  dstate_next = D_DRAIN;
      D_DRAIN:  if (drain_ok) dstate_next = D_IDLE;
      default:  dstate_next = D_IDLE;
    endcase
  end

  // Request FSM next state: stay in R_WAIT across back-to-back entries.
  always_comb begin
    rstate_next = rstate;
    case (rstate)
      R_IDLE:  if (count != '0) rstate_next = R_WAIT;
      R_WAIT:  if (sdram_ack && count_next == '0) rstate_next = R_IDLE;
      default: rstate_next = R_IDLE;
    endcase
  end

`ifdef DOWNLOAD_CHECKSUM_EN
  // Byte sum of accepted download bytes, restarted at each download start.
  always_ff @(posedge clk) begin
    if (reset)
      checksum <= 16'h0;
    else if (enter_active)
      checksum <= 16'h0;
    else if (wr_acc)
      checksum <= checksum + {8'h00, ioctl_data};
  end
`endif

  assign sdram_req     = (rstate == R_WAIT);
  assign sdram_we      = sdram_req;
  assign sdram_addr    = sdram_req ? fifo_addr[rd_ptr] : 23'h0;
  assign sdram_data    = sdram_req ? fifo_data[rd_ptr] : 32'h0;
  assign busy          = (dstate != D_IDLE);
  assign dbg_dl_state  = dstate;
  assign dbg_req_state = rstate;

endmodule

// File: tb/tb_download_sdram_writer.sv
// Bench for download_sdram_writer: table vectors, hand sequences for overflow,
// reset and latched restart, and randomized downloads against a word model.
module tb_download_sdram_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wr;
  logic [22:0] sdram_addr;
  logic [31:0] sdram_data;
  logic        sdram_we, sdram_req, sdram_ack;
  logic        busy, done, overflow;
`ifdef DOWNLOAD_CHECKSUM_EN
  logic [15:0] checksum;
`endif
  logic [1:0]  dbg_dl_state;
  logic        dbg_req_state;

  download_sdram_writer #(.FIFO_DEPTH(4), .FILL_BYTE(8'hFF)) dut (
    .clk(clk), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_addr(ioctl_addr),
    .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
    .sdram_addr(sdram_addr), .sdram_data(sdram_data), .sdram_we(sdram_we),
    .sdram_req(sdram_req), .sdram_ack(sdram_ack),
    .busy(busy), .done(done), .overflow(overflow),
`ifdef DOWNLOAD_CHECKSUM_EN
    .checksum(checksum),
`endif
    .dbg_dl_state(dbg_dl_state), .dbg_req_state(dbg_req_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  bit prev_done = 0;
  bit hold_ack = 0;
  bit rand_ack = 0;
  int ack_delay = 3;

  logic [54:0] exp_q[$];
  logic [24:0] plan_a[$];
  logic [7:0]  plan_d[$];

  typedef struct {
    int n_bytes;
    logic [7:0][24:0] addr;
    logic [7:0][7:0]  data;
    int n_exp;
    logic [2:0][54:0] exp_w;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // SDRAM controller model: acks after a delay, checks hold stability, scoreboards writes.
  initial begin : responder
    int wait_cnt;
    int cur_delay;
    bit p_req, p_ack;
    logic [22:0] p_addr;
    logic [31:0] p_data;
    wait_cnt = 0; cur_delay = 0; p_req = 0; p_ack = 0; p_addr = '0; p_data = '0;
    sdram_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      sdram_ack = 1'b0;
      if (reset) begin
        p_req = 0; p_ack = 0; wait_cnt = 0;
        continue;
      end
      if (sdram_req) begin
        if (p_req && !p_ack) begin
          check("hold_addr", sdram_addr, p_addr);
          check("hold_data", sdram_data, p_data);
        end else begin
          wait_cnt = 0;
          cur_delay = rand_ack ? int'($urandom_range(0, 2)) : ack_delay;
        end
        check("we_eq_req", sdram_we, 1);
        if (!hold_ack && wait_cnt >= cur_delay) begin
          sdram_ack = 1'b1;
          if (exp_q.size() == 0) begin
            check("unexpected_write", {sdram_addr, sdram_data}, 0);
          end else begin
            check("write", {sdram_addr, sdram_data}, exp_q.pop_front());
          end
        end else begin
          wait_cnt++;
        end
      end else if (p_req && !p_ack) begin
        check("req_dropped_without_ack", sdram_req, 1);
      end
      p_req = sdram_req; p_ack = sdram_ack; p_addr = sdram_addr; p_data = sdram_data;
    end
  end

  // done monitor: one-cycle pulse, busy already low.
  always @(negedge clk) begin
    if (!reset && done) begin
      done_cnt++;
      check("done_busy_low", busy, 0);
      check("done_single_cycle", prev_done, 0);
    end
    prev_done = done && !reset;
  end

  // Reference model: group bytes into words; a word ends on lane 3, on a
  // change of word address, or at the end of the download.
  function automatic logic [31:0] mk_word(input logic [3:0][7:0] l, input logic [3:0] v);
    logic [31:0] w;
    for (int n = 0; n < 4; n++) w[8*n +: 8] = v[n] ? l[n] : 8'hFF;
    return w;
  endfunction

  task automatic model_build();
    logic [3:0][7:0] lanes;
    logic [3:0] vld;
    logic [22:0] wa;
    logic [22:0] na;
    logic [1:0] ln;
    lanes = '0; vld = '0; wa = '0;
    foreach (plan_a[i]) begin
      na = plan_a[i][24:2];
      ln = plan_a[i][1:0];
      if (vld != 0 && na != wa) begin
        exp_q.push_back({wa, mk_word(lanes, vld)});
        vld = '0;
      end
      wa = na;
      lanes[ln] = plan_d[i];
      vld[ln] = 1'b1;
      if (ln == 2'd3) begin
        exp_q.push_back({wa, mk_word(lanes, vld)});
        vld = '0;
      end
    end
    if (vld != 0) exp_q.push_back({wa, mk_word(lanes, vld)});
  endtask

  // driver tasks
  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a; ioctl_data = d; ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int k = 0;
    while (done_cnt < target && k < budget) begin
      tick();
      k++;
    end
    check("done_timeout", done_cnt >= target, 1);
  endtask

  task automatic run_download(input int gmin, input int gmax);
    int d0;
    logic [15:0] sum;
    d0 = done_cnt;
    sum = 16'h0;
    foreach (plan_d[i]) sum = sum + 16'(plan_d[i]);
    ioctl_download = 1'b1;
    tick(); tick();
    foreach (plan_a[i]) begin
      send_byte(plan_a[i], plan_d[i]);
      repeat ($urandom_range(gmin, gmax)) tick();
    end
    ioctl_download = 1'b0;
    wait_done(d0 + 1, 3000);
    repeat (3) tick();
    check("done_count", done_cnt - d0, 1);
    check("sb_empty", exp_q.size(), 0);
    check("busy_after_done", busy, 0);
    check("overflow_clear", overflow, 0);
`ifdef DOWNLOAD_CHECKSUM_EN
    check("checksum", checksum, sum);
`endif
    exp_q.delete();
  endtask

  task automatic load_vec(input int v);
    plan_a.delete(); plan_d.delete(); exp_q.delete();
    for (int i = 0; i < vecs[v].n_bytes; i++) begin
      plan_a.push_back(vecs[v].addr[i]);
      plan_d.push_back(vecs[v].data[i]);
    end
    for (int j = 0; j < vecs[v].n_exp; j++) exp_q.push_back(vecs[v].exp_w[j]);
  endtask

  initial begin : watchdog
    #5ms;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : main
    int d0;
    int k;
    reset = 1'b1; ioctl_download = 1'b0; ioctl_addr = '0; ioctl_data = '0; ioctl_wr = 1'b0;
    repeat (3) tick();
    check("rst_req", sdram_req, 0);
    check("rst_we", sdram_we, 0);
    check("rst_addr", sdram_addr, 0);
    check("rst_data", sdram_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overflow", overflow, 0);
    reset = 1'b0;
    tick();

    // vector table
    vecs[0].n_bytes = 8; vecs[0].n_exp = 2;
    for (int i = 0; i < 8; i++) begin vecs[0].addr[i] = 25'(i); vecs[0].data[i] = 8'(i); end
    vecs[0].exp_w[0] = {23'h0, 32'h03020100};
    vecs[0].exp_w[1] = {23'h1, 32'h07060504};
    vecs[1].n_bytes = 5; vecs[1].n_exp = 2;
    for (int i = 0; i < 5; i++) begin vecs[1].addr[i] = 25'(32'h100 + i); vecs[1].data[i] = 8'(8'h11 + i); end
    vecs[1].exp_w[0] = {23'h40, 32'h14131211};
    vecs[1].exp_w[1] = {23'h41, 32'hFFFFFF15};
    vecs[2].n_bytes = 3; vecs[2].n_exp = 2;
    vecs[2].addr[0] = 25'h0;  vecs[2].data[0] = 8'hA0;
    vecs[2].addr[1] = 25'h1;  vecs[2].data[1] = 8'hA1;
    vecs[2].addr[2] = 25'h20; vecs[2].data[2] = 8'hA2;
    vecs[2].exp_w[0] = {23'h0, 32'hFFFFA1A0};
    vecs[2].exp_w[1] = {23'h8, 32'hFFFFFFA2};
    vecs[3].n_bytes = 2; vecs[3].n_exp = 2;
    vecs[3].addr[0] = 25'h10; vecs[3].data[0] = 8'h55;
    vecs[3].addr[1] = 25'h17; vecs[3].data[1] = 8'h66;
    vecs[3].exp_w[0] = {23'h4, 32'hFFFFFF55};
    vecs[3].exp_w[1] = {23'h5, 32'h66FFFFFF};
    vecs[4].n_bytes = 5; vecs[4].n_exp = 2;
    for (int i = 0; i < 4; i++) begin vecs[4].addr[i] = 25'(32'h1FFFFFC + i); vecs[4].data[i] = 8'(i + 1); end
    vecs[4].addr[4] = 25'h0; vecs[4].data[4] = 8'h09;
    vecs[4].exp_w[0] = {23'h7FFFFF, 32'h04030201};
    vecs[4].exp_w[1] = {23'h0, 32'hFFFFFF09};

    rand_ack = 0; ack_delay = 3;
    for (int v = 0; v < 5; v++) begin
      load_vec(v);
      run_download(1, 1);
    end

    // overflow: ack withheld while 24 sequential bytes stream in
    plan_a.delete(); plan_d.delete(); exp_q.delete();
    for (int w = 0; w < 4; w++)
      exp_q.push_back({23'(w), 8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
    hold_ack = 1; ack_delay = 0;
    d0 = done_cnt;
    ioctl_download = 1'b1;
    tick(); tick();
    for (int i = 0; i < 24; i++) send_byte(25'(i), 8'(i));
    repeat (40) tick();
    check("ovf_set", overflow, 1);
    check("ovf_req_held", sdram_req, 1);
    check("ovf_head_addr", sdram_addr, 0);
    ioctl_download = 1'b0;
    hold_ack = 0;
    wait_done(d0 + 1, 500);
    repeat (3) tick();
    check("ovf_sb_empty", exp_q.size(), 0);
    check("ovf_done_count", done_cnt - d0, 1);
    check("ovf_sticky", overflow, 1);

    // reset while a request is pending
    exp_q.delete();
    hold_ack = 1;
    ioctl_download = 1'b1;
    tick(); tick();
    for (int i = 0; i < 4; i++) send_byte(25'(32'h40 + i), 8'(8'h30 + i));
    k = 0;
    while (!sdram_req && k < 20) begin tick(); k++; end
    check("req_before_reset", sdram_req, 1);
    reset = 1'b1; ioctl_download = 1'b0;
    tick();
    check("rst_mid_req", sdram_req, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_overflow", overflow, 0);
    tick();
    reset = 1'b0;
    hold_ack = 0;
    repeat (5) begin
      tick();
      check("req_idle_after_reset", sdram_req, 0);
    end
    ack_delay = 3;
    load_vec(0);
    run_download(1, 1);

    // rising download during drain is latched and taken after done
    plan_a.delete(); plan_d.delete(); exp_q.delete();
    exp_q.push_back({23'h80, 32'hC3C2C1C0});
    hold_ack = 1;
    d0 = done_cnt;
    ioctl_download = 1'b1;
    tick(); tick();
    for (int i = 0; i < 4; i++) send_byte(25'(32'h200 + i), 8'(8'hC0 + i));
    ioctl_download = 1'b0;
    repeat (3) tick();
    check("drain_busy", busy, 1);
    ioctl_download = 1'b1;
    tick();
    ioctl_download = 1'b0;
    repeat (2) tick();
    hold_ack = 0;
    wait_done(d0 + 2, 200);
    repeat (3) tick();
    check("latched_done_count", done_cnt - d0, 2);
    check("latched_sb_empty", exp_q.size(), 0);
    check("latched_busy", busy, 0);
`ifdef DOWNLOAD_CHECKSUM_EN
    check("latched_checksum_restart", checksum, 0);

    // 256 bytes of 0xFF, then a fresh download restarts the sum
    plan_a.delete(); plan_d.delete(); exp_q.delete();
    for (int i = 0; i < 256; i++) begin plan_a.push_back(25'(i)); plan_d.push_back(8'hFF); end
    model_build();
    ack_delay = 0;
    run_download(0, 0);
    check("checksum_ff00", checksum, 16'hFF00);
    load_vec(0);
    run_download(1, 1);
`endif

    // randomized downloads against the model
    rand_ack = 1;
    for (int r = 0; r < 10; r++) begin
      int len;
      bit jump;
      logic [24:0] base;
      plan_a.delete(); plan_d.delete(); exp_q.delete();
      len = $urandom_range(1, 40);
      jump = 1'($urandom_range(0, 1));
      base = 25'($urandom());
      for (int i = 0; i < len; i++) begin
        plan_a.push_back(jump ? 25'($urandom_range(0, 63)) : base + 25'(i));
        plan_d.push_back(8'($urandom()));
      end
      model_build();
      if (jump) run_download(4, 6);
      else run_download(0, 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
